// File: rtl/wb_arb_if.sv
// Host-bus handshake (cs/we/addr/din/dout/rdy) shared by both requesters and the bus-wrapper side of wb_arb.
interface wb_arb_if;
   logic       cs;
   logic       we;
   logic [7:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       rdy;

   modport master (output cs, we, addr, din, input dout, rdy);
   modport slave  (input cs, we, addr, din, output dout, rdy);
endinterface

// File: rtl/wb_arb.sv
// Two-requester arbiter in front of the single wishbone-wrapper host port (A = CPU path, B = sequencer).
// Optional BUSY watchdog is built only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb #(
   parameter int RR_EN          = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic     clk,
   input  logic     rst,
   wb_arb_if.slave  a,
   wb_arb_if.slave  b,
   wb_arb_if.master m,
   output logic     owner,
   output logic     busy,
   output logic     to_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t     state, state_nxt;
   logic       req, win_b, timeout, finish;
   logic [7:0] rdata;

   logic       m_cs_n, m_we_n, a_rdy_n, b_rdy_n, owner_n, busy_n;
   logic [7:0] m_addr_n, m_din_n, a_dout_n, b_dout_n;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_arb: TIMEOUT_CYCLES must lie in 1..65535");
   end

   assign req    = a.cs | b.cs;
   // On a tie, round-robin hands the grant to whoever did not own the last access.
   assign win_b  = b.cs & (~a.cs | ((RR_EN != 0) & ~owner));
   assign finish = (state == BUSY) & (m.rdy | timeout);
   assign rdata  = timeout ? 8'hFF : m.dout;

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] cnt;

   // timeout already excludes m.rdy, so a same-cycle ready completes normally
   assign timeout = (state == BUSY) & ~m.rdy & (cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= 16'd0;
         to_err <= 1'b0;
      end else begin
         if (state != BUSY)
            cnt <= 16'd0;
         else if (!m.rdy)
            cnt <= cnt + 16'd1;
         if (timeout)
            to_err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign to_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req)    state_nxt = BUSY;
         BUSY:    if (finish) state_nxt = DONE;
         DONE:                state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // Next values for every registered output; the bus fields only change on a grant.
   always_comb begin
      m_cs_n   = m.cs;
      m_we_n   = m.we;
      m_addr_n = m.addr;
      m_din_n  = m.din;
      a_dout_n = a.dout;
      b_dout_n = b.dout;
      owner_n  = owner;
      a_rdy_n  = 1'b0;
      b_rdy_n  = 1'b0;
      busy_n   = (state_nxt != IDLE);
      case (state)
         IDLE: begin
            if (req) begin
               m_cs_n   = 1'b1;
               owner_n  = win_b;
               m_we_n   = win_b ? b.we   : a.we;
               m_addr_n = win_b ? b.addr : a.addr;
               m_din_n  = win_b ? b.din  : a.din;
            end
         end
         BUSY: begin
            if (finish) begin
               m_cs_n  = 1'b0;
               a_rdy_n = ~owner;
               b_rdy_n = owner;
               if (owner)
                  b_dout_n = rdata;
               else
                  a_dout_n = rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m.cs   <= 1'b0;
         m.we   <= 1'b0;
         m.addr <= 8'h00;
         m.din  <= 8'h00;
         a.dout <= 8'h00;
         b.dout <= 8'h00;
         a.rdy  <= 1'b0;
         b.rdy  <= 1'b0;
         owner  <= 1'b1;
         busy   <= 1'b0;
      end else begin
         m.cs   <= m_cs_n;
         m.we   <= m_we_n;
         m.addr <= m_addr_n;
         m.din  <= m_din_n;
         a.dout <= a_dout_n;
         b.dout <= b_dout_n;
         a.rdy  <= a_rdy_n;
         b.rdy  <= b_rdy_n;
         owner  <= owner_n;
         busy   <= busy_n;
      end
   end

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: dut0 is round-robin (TIMEOUT_CYCLES=16), dut1 is fixed priority.
module tb_wb_arb;
   logic clk;
   logic rst;

   wb_arb_if ia0 ();
   wb_arb_if ib0 ();
   wb_arb_if im0 ();
   wb_arb_if ia1 ();
   wb_arb_if ib1 ();
   wb_arb_if im1 ();

   logic owner0, busy0, to_err0;
   logic owner1, busy1, to_err1;

   int compared   = 0;
   int mismatched = 0;

   int lat0 = 3;
   int lat1 = 3;
   int a_pulses0 = 0, b_pulses0 = 0, acc0 = 0;
   int a_pulses1 = 0, b_pulses1 = 0, acc1 = 0;
   logic       glog0 [64];
   logic       glog1 [64];
   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];

   wb_arb #(.RR_EN(1), .TIMEOUT_CYCLES(16)) dut0 (
      .clk(clk), .rst(rst), .a(ia0), .b(ib0), .m(im0),
      .owner(owner0), .busy(busy0), .to_err(to_err0)
   );

   wb_arb #(.RR_EN(0), .TIMEOUT_CYCLES(16)) dut1 (
      .clk(clk), .rst(rst), .a(ia1), .b(ib1), .m(im1),
      .owner(owner1), .busy(busy1), .to_err(to_err1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bus-wrapper models: ready lat cycles after cs is seen (lat=0 never answers); writes return 8'h11.
   initial begin : model0
      int   cnt;
      logic prev;
      for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
      mem0[8'h2C] = 8'hC3;
      cnt = 0; prev = 1'b0;
      im0.rdy = 1'b0; im0.dout = 8'h00;
      forever begin
         @(negedge clk);
         if (ia0.rdy) a_pulses0++;
         if (ib0.rdy) b_pulses0++;
         if (im0.cs && !prev) begin
            glog0[acc0 % 64] = owner0;
            acc0++;
         end
         prev = im0.cs;
         if (im0.cs && !im0.rdy && lat0 != 0) begin
            cnt++;
            if (cnt >= lat0) begin
               im0.rdy = 1'b1;
               if (im0.we) begin
                  mem0[im0.addr] = im0.din;
                  im0.dout = 8'h11;
               end else begin
                  im0.dout = mem0[im0.addr];
               end
               cnt = 0;
            end
         end else begin
            im0.rdy = 1'b0;
            cnt = 0;
         end
      end
   end

   initial begin : model1
      int   cnt;
      logic prev;
      for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
      mem1[8'h2C] = 8'hC3;
      cnt = 0; prev = 1'b0;
      im1.rdy = 1'b0; im1.dout = 8'h00;
      forever begin
         @(negedge clk);
         if (ia1.rdy) a_pulses1++;
         if (ib1.rdy) b_pulses1++;
         if (im1.cs && !prev) begin
            glog1[acc1 % 64] = owner1;
            acc1++;
         end
         prev = im1.cs;
         if (im1.cs && !im1.rdy && lat1 != 0) begin
            cnt++;
            if (cnt >= lat1) begin
               im1.rdy = 1'b1;
               if (im1.we) begin
                  mem1[im1.addr] = im1.din;
                  im1.dout = 8'h11;
               end else begin
                  im1.dout = mem1[im1.addr];
               end
               cnt = 0;
            end
         end else begin
            im1.rdy = 1'b0;
            cnt = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy_of(input int d, input bit is_b);
      if (d == 0) return is_b ? ib0.rdy : ia0.rdy;
      return is_b ? ib1.rdy : ia1.rdy;
   endfunction

   task automatic wait_rdy(input string tag, input int d, input bit is_b);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = rdy_of(d, is_b);
      end
      check(tag, 16'(seen), 16'd1);
   endtask

   task automatic wait_any(input string tag, input int d);
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = rdy_of(d, 1'b0) | rdy_of(d, 1'b1);
      end
      check(tag, 16'(seen), 16'd1);
   endtask

   initial begin : main
      int base, bbase, g, hi_cnt;
      ia0.cs = 0; ia0.we = 0; ia0.addr = 0; ia0.din = 0;
      ib0.cs = 0; ib0.we = 0; ib0.addr = 0; ib0.din = 0;
      ia1.cs = 0; ia1.we = 0; ia1.addr = 0; ia1.din = 0;
      ib1.cs = 0; ib1.we = 0; ib1.addr = 0; ib1.din = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_m_cs",   16'(im0.cs),   16'd0);
      check("rst_m_we",   16'(im0.we),   16'd0);
      check("rst_m_addr", 16'(im0.addr), 16'h00);
      check("rst_m_din",  16'(im0.din),  16'h00);
      check("rst_a_dout", 16'(ia0.dout), 16'h00);
      check("rst_b_dout", 16'(ib0.dout), 16'h00);
      check("rst_a_rdy",  16'(ia0.rdy),  16'd0);
      check("rst_owner",  16'(owner0),   16'd1);
      check("rst_busy",   16'(busy0),    16'd0);
      check("rst_to_err", 16'(to_err0),  16'd0);
      @(negedge clk) rst = 1'b1;

      // Lone A write: exact latency with a 3-cycle bus
      @(negedge clk);
      base = a_pulses0; bbase = b_pulses0;
      ia0.cs = 1; ia0.we = 1; ia0.addr = 8'h08; ia0.din = 8'h5A;
      @(negedge clk);
      check("aw_m_cs",   16'(im0.cs),   16'd1);
      check("aw_m_we",   16'(im0.we),   16'd1);
      check("aw_m_addr", 16'(im0.addr), 16'h08);
      check("aw_m_din",  16'(im0.din),  16'h5A);
      check("aw_owner",  16'(owner0),   16'd0);
      check("aw_busy",   16'(busy0),    16'd1);
      repeat (3) @(negedge clk);
      check("aw_a_rdy",     16'(ia0.rdy),  16'd1);
      check("aw_b_rdy",     16'(ib0.rdy),  16'd0);
      check("aw_busy_done", 16'(busy0),    16'd1);
      check("aw_a_dout",    16'(ia0.dout), 16'h11);
      ia0.cs = 0;
      @(negedge clk);
      check("aw_rdy_fall", 16'(ia0.rdy), 16'd0);
      check("aw_idle",     16'(busy0),   16'd0);
      repeat (2) @(negedge clk);
      check("aw_a_pulses", 16'(a_pulses0 - base),  16'd1);
      check("aw_b_pulses", 16'(b_pulses0 - bbase), 16'd0);
      check("aw_mem",      16'(mem0[8'h08]),       16'h5A);

      // Lone B read of 0x2C
      ib0.cs = 1; ib0.we = 0; ib0.addr = 8'h2C; ib0.din = 8'h00;
      wait_rdy("br_seen", 0, 1'b1);
      check("br_b_dout",  16'(ib0.dout), 16'hC3);
      check("br_a_rdy",   16'(ia0.rdy),  16'd0);
      check("br_owner",   16'(owner0),   16'd1);
      ib0.cs = 0;
      @(negedge clk);
      check("br_b_hold", 16'(ib0.dout), 16'hC3);
      check("br_b_rdy0", 16'(ib0.rdy),  16'd0);
      check("br_a_kept", 16'(ia0.dout), 16'h11);

      // Continuous tie, round-robin: A,B,A,B
      g = acc0;
      ia0.cs = 1; ia0.we = 1; ia0.addr = 8'h10; ia0.din = 8'h01;
      ib0.cs = 1; ib0.we = 1; ib0.addr = 8'h20; ib0.din = 8'h02;
      for (int k = 0; k < 4; k++) wait_any($sformatf("rr_done%0d", k), 0);
      ia0.cs = 0; ib0.cs = 0;
      repeat (3) @(negedge clk);
      check("rr_count", 16'(acc0 - g), 16'd4);
      check("rr_g0", 16'(glog0[(g + 0) % 64]), 16'd0);
      check("rr_g1", 16'(glog0[(g + 1) % 64]), 16'd1);
      check("rr_g2", 16'(glog0[(g + 2) % 64]), 16'd0);
      check("rr_g3", 16'(glog0[(g + 3) % 64]), 16'd1);

      // Continuous tie, fixed priority: A,A,A with B starved
      g = acc1; bbase = b_pulses1;
      ia1.cs = 1; ia1.we = 1; ia1.addr = 8'h30; ia1.din = 8'h03;
      ib1.cs = 1; ib1.we = 1; ib1.addr = 8'h40; ib1.din = 8'h04;
      for (int k = 0; k < 3; k++) wait_any($sformatf("fp_done%0d", k), 1);
      ia1.cs = 0; ib1.cs = 0;
      repeat (3) @(negedge clk);
      check("fp_count",    16'(acc1 - g), 16'd3);
      check("fp_g0",       16'(glog1[(g + 0) % 64]), 16'd0);
      check("fp_g1",       16'(glog1[(g + 1) % 64]), 16'd0);
      check("fp_g2",       16'(glog1[(g + 2) % 64]), 16'd0);
      check("fp_b_starve", 16'(b_pulses1 - bbase), 16'd0);

      // A drops cs right after grant: still completes, single access
      g = acc0; base = a_pulses0;
      ia0.cs = 1; ia0.we = 0; ia0.addr = 8'h08; ia0.din = 8'h00;
      @(negedge clk);
      check("drop_granted", 16'(im0.cs), 16'd1);
      ia0.cs = 0;
      wait_rdy("drop_seen", 0, 1'b0);
      check("drop_a_dout", 16'(ia0.dout), 16'h5A);
      repeat (4) @(negedge clk);
      check("drop_one_acc",  16'(acc0 - g),         16'd1);
      check("drop_one_rdy",  16'(a_pulses0 - base), 16'd1);

      // Reset while BUSY
      lat0 = 0;
      ia0.cs = 1; ia0.we = 0; ia0.addr = 8'h2C;
      @(negedge clk);
      check("rb_busy_cs", 16'(im0.cs), 16'd1);
      #2 rst = 1'b0;
      #1;
      check("rb_async_cs",   16'(im0.cs), 16'd0);
      check("rb_async_busy", 16'(busy0),  16'd0);
      ia0.cs = 0;
      @(negedge clk) rst = 1'b1;
      base = a_pulses0;
      repeat (4) @(negedge clk);
      check("rb_no_rdy", 16'(a_pulses0 - base), 16'd0);
      check("rb_owner",  16'(owner0),   16'd1);
      check("rb_a_dout", 16'(ia0.dout), 16'h00);
      lat0 = 2;
      ia0.cs = 1; ia0.we = 0; ia0.addr = 8'h2C;
      wait_rdy("rb_after_seen", 0, 1'b0);
      check("rb_after_owner", 16'(owner0),   16'd0);
      check("rb_after_dout",  16'(ia0.dout), 16'hC3);
      ia0.cs = 0;
      @(negedge clk);

`ifdef WB_ARB_TIMEOUT_EN
      // Unanswered access: forced completion after 16 BUSY cycles
      lat0 = 0;
      ia0.cs = 1; ia0.we = 0; ia0.addr = 8'h2C;
      hi_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!im0.cs && i > 0) break;
         if (im0.cs) hi_cnt++;
      end
      check("to_busy_cycles", 16'(hi_cnt),   16'd16);
      check("to_a_rdy",       16'(ia0.rdy),  16'd1);
      check("to_a_dout",      16'(ia0.dout), 16'hFF);
      check("to_flag",        16'(to_err0),  16'd1);
      ia0.cs = 0;
      lat0 = 2;
      @(negedge clk);
      ib0.cs = 1; ib0.we = 0; ib0.addr = 8'h2C;
      wait_rdy("to_next_seen", 0, 1'b1);
      check("to_next_dout", 16'(ib0.dout), 16'hC3);
      ib0.cs = 0;
      @(negedge clk);
      check("to_flag_sticky", 16'(to_err0), 16'd1);
`else
      check("no_to_err0", 16'(to_err0), 16'd0);
      check("no_to_err1", 16'(to_err1), 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
